// File: rtl/router_pkg.sv
// Shared types for the NoC router input path: framing states, flit tag bits
// and the default flit width.
package router_pkg;

  localparam int DEFAULT_FLIT_WIDTH = 32;

  typedef enum logic [1:0] {
    WAIT_HEADER = 2'd0,
    WAIT_SIZE   = 2'd1,
    PAYLOAD     = 2'd2
  } frame_state_t;

  typedef struct packed {
    logic sof;
    logic eof;
  } flit_tag_t;

endpackage

// File: rtl/flit_fifo.sv
// Flit storage for the router input buffer: circular buffer with
// first-word-fall-through read; push/pop are pre-qualified by the caller.
module flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Head reads as zero while empty so the output is defined out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/router_input_buffer.sv
// NoC router input port: FWFT flit buffer with packet framing and credit
// flow control. Optional stats counters under ROUTER_IBUF_STATS_EN.
module router_input_buffer
  import router_pkg::*;
#(
  parameter int FLIT_WIDTH = DEFAULT_FLIT_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  output logic                  sof_o,
  output logic                  eof_o,
  input  logic                  credit_i,
  output logic [FLIT_WIDTH-1:0] dest_o,
  output logic                  overflow_o
`ifdef ROUTER_IBUF_STATS_EN
  ,
  output logic [31:0]           flits_in_o,
  output logic [31:0]           pkts_in_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  // One slot held back: upstream acts on credit a cycle after sampling it.
  localparam logic [AW:0] CREDIT_LIMIT = (AW+1)'(DEPTH - 2);

  logic [AW:0]           count;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  accept;
  flit_tag_t             wr_tag;
  flit_tag_t             rd_tag;
  logic [FLIT_WIDTH+1:0] rd_entry;
  frame_state_t          state;
  frame_state_t          state_next;
  logic [FLIT_WIDTH-1:0] remaining;

  assign tx       = !empty;
  assign pop      = tx && credit_i;
  assign accept   = rx && (!full || pop);
  assign credit_o = (count <= CREDIT_LIMIT);

  flit_fifo #(
    .WIDTH (FLIT_WIDTH + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (accept),
    .wr_data ({wr_tag, data_i}),
    .pop     (pop),
    .rd_data (rd_entry),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign {rd_tag, data_o} = rd_entry;
  assign sof_o = rd_tag.sof;
  assign eof_o = rd_tag.eof;

  always_comb begin
    wr_tag     = '0;
    state_next = state;
    case (state)
      WAIT_HEADER: begin
        wr_tag.sof = 1'b1;
        state_next = WAIT_SIZE;
      end
      WAIT_SIZE: begin
        if (data_i == '0) begin
          wr_tag.eof = 1'b1;
          state_next = WAIT_HEADER;
        end else begin
          state_next = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (remaining == FLIT_WIDTH'(1)) begin
          wr_tag.eof = 1'b1;
          state_next = WAIT_HEADER;
        end
      end
      default: state_next = WAIT_HEADER;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_HEADER;
      remaining <= '0;
      dest_o    <= '0;
    end else if (accept) begin
      state <= state_next;
      case (state)
        WAIT_HEADER: dest_o    <= data_i;
        WAIT_SIZE:   remaining <= data_i;
        PAYLOAD:     remaining <= (remaining == '0) ? '0 : remaining - FLIT_WIDTH'(1);
        default:     remaining <= remaining;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_o <= 1'b0;
    end else if (rx && !accept) begin
      overflow_o <= 1'b1;
    end
  end

`ifdef ROUTER_IBUF_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flits_in_o <= '0;
      pkts_in_o  <= '0;
    end else if (accept) begin
      flits_in_o <= flits_in_o + 32'd1;
      if (wr_tag.eof) pkts_in_o <= pkts_in_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed packet/credit/reset scenarios plus
// randomized traffic against a queue-based packet model.
module tb_router_input_buffer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] data_i;
  logic        credit_o;
  logic        tx;
  logic [31:0] data_o;
  logic        sof_o;
  logic        eof_o;
  logic        credit_i;
  logic [31:0] dest_o;
  logic        overflow_o;
`ifdef ROUTER_IBUF_STATS_EN
  logic [31:0] flits_in_o;
  logic [31:0] pkts_in_o;
`endif

  router_input_buffer #(
    .FLIT_WIDTH (32),
    .DEPTH      (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .data_i     (data_i),
    .credit_o   (credit_o),
    .tx         (tx),
    .data_o     (data_o),
    .sof_o      (sof_o),
    .eof_o      (eof_o),
    .credit_i   (credit_i),
    .dest_o     (dest_o),
    .overflow_o (overflow_o)
`ifdef ROUTER_IBUF_STATS_EN
    ,
    .flits_in_o (flits_in_o),
    .pkts_in_o  (pkts_in_o)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] d;
    logic        sof;
    logic        eof;
  } ent_t;

  ent_t            mq[$];
  logic [31:0]     stream[$];
  bit              m_ovf;
  logic [31:0]     m_dest;
  longint unsigned m_idx;
  logic [31:0]     m_len;
  int unsigned     m_flits;
  int unsigned     m_pkts;
  int              errors = 0;
  int              checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf   = 1'b0;
    m_dest  = '0;
    m_idx   = 0;
    m_len   = '0;
    m_flits = 0;
    m_pkts  = 0;
  endtask

  // Packet position counts flits since the last eof: 0 header, 1 size, 2.. payload.
  task automatic model_edge(input logic r, input logic [31:0] d, input logic c);
    bit   do_pop;
    bit   acc;
    ent_t e;
    do_pop = (mq.size() > 0) && c;
    acc    = r && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) mq.delete(0);
    if (r && !acc) m_ovf = 1'b1;
    if (acc) begin
      e.d   = d;
      e.sof = (m_idx == 0);
      e.eof = 1'b0;
      if (m_idx == 0) m_dest = d;
      else if (m_idx == 1) begin
        m_len = d;
        e.eof = (d == 0);
      end else e.eof = ((m_idx - 1) == 64'(m_len));
      m_idx = e.eof ? 0 : m_idx + 1;
      m_flits++;
      if (e.eof) m_pkts++;
      mq.push_back(e);
    end
  endtask

  task automatic check_all();
    chk("tx", 32'(tx), 32'(mq.size() != 0));
    chk("credit_o", 32'(credit_o), 32'(mq.size() <= DEPTH - 2));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
    chk("dest_o", dest_o, m_dest);
    if (mq.size() != 0) begin
      chk("data_o", data_o, mq[0].d);
      chk("sof_o", 32'(sof_o), 32'(mq[0].sof));
      chk("eof_o", 32'(eof_o), 32'(mq[0].eof));
    end
`ifdef ROUTER_IBUF_STATS_EN
    chk("flits_in_o", flits_in_o, m_flits);
    chk("pkts_in_o", pkts_in_o, m_pkts);
`endif
  endtask

  task automatic cycle(input logic r, input logic [31:0] d, input logic c);
    rx       = r;
    data_i   = d;
    credit_i = c;
    @(posedge clock);
    if (reset) model_edge(r, d, c);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    cycle(1'b0, '0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    rx       = 1'b0;
    data_i   = '0;
    credit_i = 1'b0;
    model_reset();
    #1;
    chk("rst_tx", 32'(tx), 32'd0);
    chk("rst_credit", 32'(credit_o), 32'd1);
    chk("rst_data", data_o, 32'd0);
    chk("rst_sof", 32'(sof_o), 32'd0);
    chk("rst_eof", 32'(eof_o), 32'd0);
    chk("rst_dest", dest_o, 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    cycle(1'b0, '0, 1'b0);
    reset = 1'b1;

    // Single packet with 3 payload flits, streaming straight through.
    cycle(1'b1, 32'h11, 1'b1);
    chk("pkt1_hdr_sof", 32'(sof_o), 32'd1);
    cycle(1'b1, 32'd3, 1'b1);
    cycle(1'b1, 32'hA, 1'b1);
    cycle(1'b1, 32'hB, 1'b1);
    cycle(1'b1, 32'hC, 1'b1);
    chk("pkt1_last_eof", 32'(eof_o), 32'd1);
    chk("pkt1_dest", dest_o, 32'h11);
    cycle(1'b0, '0, 1'b1);
    chk("pkt1_drained", 32'(tx), 32'd0);

    // Size-zero packet, then a fresh header.
    cycle(1'b1, 32'h22, 1'b1);
    cycle(1'b1, 32'd0, 1'b1);
    chk("size0_eof", 32'(eof_o), 32'd1);
    cycle(1'b1, 32'h55, 1'b1);
    chk("after0_sof", 32'(sof_o), 32'd1);
    chk("after0_dest", dest_o, 32'h55);
    cycle(1'b1, 32'd0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Back-to-back pushes with the switch stalled: credit and overflow.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, (i == 1) ? 32'h66 : ((i == 2) ? 32'd20 : 32'(i)), 1'b0);
      if (i == 6) chk("credit_at6", 32'(credit_o), 32'd1);
      if (i == 7) chk("credit_at7", 32'(credit_o), 32'd0);
      if (i == 8) chk("ovf_at8", 32'(overflow_o), 32'd0);
    end
    chk("ovf_at9", 32'(overflow_o), 32'd1);
    chk("full_head", data_o, 32'h66);

    // Full FIFO with simultaneous push and pop: no overflow.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 1) ? 32'd30 : 32'(i + 100), 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i + 200), 1'b1);
    chk("full_swap_ovf", 32'(overflow_o), 32'd0);
    chk("full_swap_credit", 32'(credit_o), 32'd0);
    cycle(1'b1, 32'h77, 1'b0);
    chk("full_push_ovf", 32'(overflow_o), 32'd1);

    // Reset asserted mid-payload clears the buffer at once.
    do_reset();
    cycle(1'b1, 32'h33, 1'b0);
    cycle(1'b1, 32'd5, 1'b0);
    cycle(1'b1, 32'hD1, 1'b0);
    cycle(1'b1, 32'hD2, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_tx", 32'(tx), 32'd0);
    chk("midrst_credit", 32'(credit_o), 32'd1);
    chk("midrst_dest", dest_o, 32'd0);
    cycle(1'b0, '0, 1'b0);
    reset = 1'b1;
    cycle(1'b1, 32'h44, 1'b1);
    chk("midrst_sof", 32'(sof_o), 32'd1);
    chk("midrst_newdest", dest_o, 32'h44);
    cycle(1'b1, 32'd0, 1'b1);

`ifdef ROUTER_IBUF_STATS_EN
    do_reset();
    for (int i = 0; i < 11; i++) begin
      logic [31:0] seq [11];
      seq = '{32'h1, 32'd0, 32'h2, 32'd1, 32'hE1, 32'h3, 32'd4, 32'hF1, 32'hF2, 32'hF3, 32'hF4};
      cycle(1'b1, seq[i], 1'b1);
    end
    chk("stats_flits", flits_in_o, 32'd11);
    chk("stats_pkts", pkts_in_o, 32'd3);
`endif

    // Random well-formed packets, upstream honouring credit_o.
    do_reset();
    for (int p = 0; p < 40; p++) begin
      int unsigned sz;
      sz = $urandom_range(0, 5);
      stream.push_back($urandom);
      stream.push_back(sz);
      for (int k = 0; k < int'(sz); k++) stream.push_back($urandom);
    end
    for (int n = 0; n < 1500 && stream.size() > 0; n++) begin
      logic r;
      r = credit_o && ($urandom_range(0, 3) != 0);
      cycle(r, r ? stream[0] : $urandom, $urandom_range(0, 2) != 0);
      if (r) stream.delete(0);
    end
    chk("stream_done", 32'(stream.size()), 32'd0);
    for (int n = 0; n < 12; n++) cycle(1'b0, '0, 1'b1);

    // Random traffic ignoring credit, small values keep packets short.
    for (int n = 0; n < 300; n++)
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 2) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
